// File: rtl/bar_symbol_assembler.sv
// ---------------------------------------------------------------------------
// bar_symbol_assembler
//
// Front end of the 2-of-5 barcode decoder. Synchronises the raw scanner line,
// measures every dark bar in clock cycles, collects five bar widths, sorts
// them into narrow/wide against a threshold derived from the group itself,
// and hands a validated 5-bit symbol to the downstream decoding FSM.
//
// Ports:
//   clock      in   system clock, rising edge
//   I_Reset_n  in   asynchronous active-low reset
//   I_Scan     in   raw scanner line (1 = bar, 0 = space), asynchronous
//   O_I        out  last valid symbol, first bar = bit 4, 1 = wide bar
//   O_PG       out  one-cycle strobe, new valid symbol on O_I
//   O_Err      out  one-cycle strobe, symbol rejected or aborted
//   O_Busy     out  high while a symbol is being assembled
// ---------------------------------------------------------------------------
module bar_symbol_assembler #(
  parameter int CNT_W   = 8,
  parameter int MIN_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       I_Reset_n,
  input  logic       I_Scan,
  output logic [4:0] O_I,
  output logic       O_PG,
  output logic       O_Err,
  output logic       O_Busy
);

  localparam int SCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BAR,
    S_SPACE,
    S_EVAL,
    S_EMIT
  } state_t;

  state_t            state_q, state_d;
  logic              scanS1_q, scanS2_q;
  logic [CNT_W-1:0]  barCnt_q, barCnt_d;
  logic [SCNT_W-1:0] spaceCnt_q, spaceCnt_d;
  logic [2:0]        barIdx_q, barIdx_d;
  logic [CNT_W-1:0]  width_q [5];
  logic [CNT_W-1:0]  width_d [5];
  logic [4:0]        bits_q, bits_d;
  logic [CNT_W-1:0]  minW_q, minW_d;
  logic [CNT_W-1:0]  maxW_q, maxW_d;
  logic [4:0]        sym_q, sym_d;
  logic              pg_q, pg_d;
  logic              err_q, err_d;
  logic              busy_q;

  // Evaluation helpers, only meaningful while the FSM sits in S_EVAL/S_EMIT.
  logic [CNT_W-1:0]  evalMin, evalMax;
  logic [CNT_W:0]    evalThr;
  logic [4:0]        evalBits;
  logic [2:0]        wideCount;
  logic              symbolValid;

  // Two-flop synchroniser for the asynchronous scanner line; only the second
  // stage is ever looked at by the FSM.
  always_ff @(posedge clock or negedge I_Reset_n) begin
    if (!I_Reset_n) begin
      scanS1_q <= 1'b0;
      scanS2_q <= 1'b0;
    end else begin
      scanS1_q <= I_Scan;
      scanS2_q <= scanS1_q;
    end
  end

  // Min/max of the five captured widths and the midpoint threshold. The sum
  // is one bit wider than a width so that two saturated-range widths cannot
  // wrap before the halving.
  always_comb begin
    evalMin  = width_q[0];
    evalMax  = width_q[0];
    evalThr  = '0;
    evalBits = '0;
    for (int k = 1; k < 5; k++) begin
      if (width_q[k] < evalMin) evalMin = width_q[k];
      if (width_q[k] > evalMax) evalMax = width_q[k];
    end
    evalThr = ({1'b0, evalMin} + {1'b0, evalMax}) >> 1;
    for (int k = 0; k < 5; k++) begin
      evalBits[4-k] = ({1'b0, width_q[k]} > evalThr);
    end
  end

  // A 2-of-5 symbol needs exactly two wide bars, and the widest bar must be
  // at least twice the narrowest so that a uniform group is never accepted.
  always_comb begin
    wideCount = '0;
    for (int k = 0; k < 5; k++) begin
      wideCount = wideCount + {2'b00, bits_q[k]};
    end
    symbolValid = (wideCount == 3'd2) && ({1'b0, maxW_q} >= {minW_q, 1'b0});
  end

  // Next-state and output logic. Strobes default low so they last exactly one
  // cycle; the symbol register only moves on an accepted group.
  always_comb begin
    state_d    = state_q;
    barCnt_d   = barCnt_q;
    spaceCnt_d = spaceCnt_q;
    barIdx_d   = barIdx_q;
    bits_d     = bits_q;
    minW_d     = minW_q;
    maxW_d     = maxW_q;
    sym_d      = sym_q;
    pg_d       = 1'b0;
    err_d      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      width_d[k] = width_q[k];
    end

    unique case (state_q)
      S_IDLE: begin
        barIdx_d = '0;
        if (scanS2_q) begin
          state_d  = S_BAR;
          barCnt_d = CNT_W'(1);
        end
      end

      S_BAR: begin
        if (scanS2_q) begin
          if (barCnt_q != CNT_MAX) barCnt_d = barCnt_q + CNT_W'(1);
        end else if ((barCnt_q < CNT_W'(MIN_W)) || (barCnt_q == CNT_MAX)) begin
          // Glitch or a bar too long to measure: drop the whole group.
          err_d    = 1'b1;
          barIdx_d = '0;
          state_d  = S_IDLE;
        end else begin
          for (int k = 0; k < 5; k++) begin
            if (barIdx_q == 3'(k)) width_d[k] = barCnt_q;
          end
          barIdx_d = barIdx_q + 3'd1;
          if (barIdx_q == 3'd4) begin
            state_d = S_EVAL;
          end else begin
            state_d    = S_SPACE;
            spaceCnt_d = SCNT_W'(1);
          end
        end
      end

      S_SPACE: begin
        if (scanS2_q) begin
          state_d  = S_BAR;
          barCnt_d = CNT_W'(1);
        end else begin
          spaceCnt_d = spaceCnt_q + SCNT_W'(1);
          if (spaceCnt_d == SCNT_W'(TIMEOUT)) begin
            // The line went quiet in the middle of a symbol.
            err_d    = 1'b1;
            barIdx_d = '0;
            state_d  = S_IDLE;
          end
        end
      end

      S_EVAL: begin
        bits_d  = evalBits;
        minW_d  = evalMin;
        maxW_d  = evalMax;
        state_d = S_EMIT;
      end

      S_EMIT: begin
        if (symbolValid) begin
          sym_d = bits_q;
          pg_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        barIdx_d = '0;
        state_d  = S_IDLE;
      end

      default: begin
        barIdx_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset throws away any partly captured
  // group along with the last delivered symbol.
  always_ff @(posedge clock or negedge I_Reset_n) begin
    if (!I_Reset_n) begin
      state_q    <= S_IDLE;
      barCnt_q   <= '0;
      spaceCnt_q <= '0;
      barIdx_q   <= '0;
      bits_q     <= '0;
      minW_q     <= '0;
      maxW_q     <= '0;
      sym_q      <= '0;
      pg_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        width_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      barCnt_q   <= barCnt_d;
      spaceCnt_q <= spaceCnt_d;
      barIdx_q   <= barIdx_d;
      bits_q     <= bits_d;
      minW_q     <= minW_d;
      maxW_q     <= maxW_d;
      sym_q      <= sym_d;
      pg_q       <= pg_d;
      err_q      <= err_d;
      busy_q     <= (state_d != S_IDLE);
      for (int k = 0; k < 5; k++) begin
        width_q[k] <= width_d[k];
      end
    end
  end

  assign O_I    = sym_q;
  assign O_PG   = pg_q;
  assign O_Err  = err_q;
  assign O_Busy = busy_q;

endmodule

// File: tb/tb_bar_symbol_assembler.sv
// ---------------------------------------------------------------------------
// tb_bar_symbol_assembler
//
// Drives bar/space patterns into bar_symbol_assembler and checks the decoded
// symbol, strobe counts, strobe timing and error handling against expected
// values worked out from the bar widths.
// ---------------------------------------------------------------------------
module tb_bar_symbol_assembler;

  logic       clock;
  logic       I_Reset_n;
  logic       I_Scan;
  logic [4:0] O_I;
  logic       O_PG;
  logic       O_Err;
  logic       O_Busy;

  bar_symbol_assembler #(
    .CNT_W  (8),
    .MIN_W  (2),
    .TIMEOUT(64)
  ) dut (
    .clock    (clock),
    .I_Reset_n(I_Reset_n),
    .I_Scan   (I_Scan),
    .O_I      (O_I),
    .O_PG     (O_PG),
    .O_Err    (O_Err),
    .O_Busy   (O_Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Observed-event bookkeeping, gathered just after every rising edge.
  int         cyc = 0;
  int         pgCount = 0;
  int         errCount = 0;
  int         lastPgCyc = -1;
  int         lastErrCyc = -1;
  int         invViol = 0;
  logic [4:0] prevOI = '0;

  // Symbol the design should currently be holding on O_I.
  logic [4:0] expOI = '0;

  typedef struct {
    logic [0:4][7:0] w;
    logic            expValid;
    logic [4:0]      expSym;
    string           name;
  } vec_t;

  vec_t vecs[5];

  // Counts strobes and watches the two output invariants: PG and Err never
  // together, and O_I only moves with PG.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (O_PG) begin
      pgCount++;
      lastPgCyc = cyc;
    end
    if (O_Err) begin
      errCount++;
      lastErrCyc = cyc;
    end
    if (O_PG && O_Err) invViol++;
    if ((O_I !== prevOI) && !O_PG && I_Reset_n) invViol++;
    prevOI = O_I;
  end

  // Reset legitimately clears O_I without a strobe.
  always @(negedge I_Reset_n) prevOI = '0;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Holds the line at v for n sampled rising edges; called at a falling edge.
  task automatic holdLine(input logic v, input int n);
    I_Scan = v;
    repeat (n) @(negedge clock);
  endtask

  // Reference model: classify five widths straight from the symbol rules.
  function automatic void modelGroup(input logic [0:4][7:0] w,
                                     output logic valid, output logic [4:0] sym);
    int mn, mx, thr, wide;
    mn = w[0];
    mx = w[0];
    for (int k = 1; k < 5; k++) begin
      if (int'(w[k]) < mn) mn = w[k];
      if (int'(w[k]) > mx) mx = w[k];
    end
    thr  = (mn + mx) / 2;
    wide = 0;
    sym  = '0;
    for (int k = 0; k < 5; k++) begin
      if (int'(w[k]) > thr) begin
        sym[4-k] = 1'b1;
        wide++;
      end
    end
    valid = (wide == 2) && (mx >= 2 * mn);
  endfunction

  // Sends five bars separated by sp-cycle spaces, then keeps the line low
  // for a dozen cycles. jCyc is the first edge that samples the final fall.
  task automatic applyStimulus(input logic [0:4][7:0] w, input int sp, output int jCyc);
    for (int k = 0; k < 5; k++) begin
      holdLine(1'b1, int'(w[k]));
      if (k < 4) holdLine(1'b0, sp);
    end
    I_Scan = 1'b0;
    jCyc = cyc + 1;
    repeat (12) @(negedge clock);
  endtask

  task automatic runGroup(input string name, input logic [0:4][7:0] w, input int sp,
                          input logic expValid, input logic [4:0] expSym);
    int pg0, e0, j;
    pg0 = pgCount;
    e0  = errCount;
    applyStimulus(w, sp, j);
    if (expValid) expOI = expSym;
    checkOutput({name, " pg pulses"}, pgCount - pg0, expValid ? 1 : 0);
    checkOutput({name, " err pulses"}, errCount - e0, expValid ? 0 : 1);
    checkOutput({name, " symbol"}, int'(O_I), int'(expOI));
    checkOutput({name, " busy after"}, int'(O_Busy), 0);
  endtask

  initial begin
    int               j, pg0, e0;
    logic [0:4][7:0]  rw;
    logic             mValid;
    logic [4:0]       mSym;
    int               nar, p1, p2;

    I_Scan    = 1'b0;
    I_Reset_n = 1'b0;

    vecs[0] = '{w: {8'd3, 8'd3, 8'd9, 8'd9, 8'd3},  expValid: 1'b1, expSym: 5'b00110, name: "g33993"};
    vecs[1] = '{w: {8'd4, 8'd12, 8'd4, 8'd4, 8'd12}, expValid: 1'b1, expSym: 5'b01001, name: "g4c44c"};
    vecs[2] = '{w: {8'd5, 8'd5, 8'd5, 8'd5, 8'd5},   expValid: 1'b0, expSym: 5'b00000, name: "g55555"};
    vecs[3] = '{w: {8'd3, 8'd9, 8'd9, 8'd9, 8'd3},   expValid: 1'b0, expSym: 5'b00000, name: "g39993"};
    vecs[4] = '{w: {8'd9, 8'd3, 8'd3, 8'd3, 8'd9},   expValid: 1'b1, expSym: 5'b10001, name: "g93339"};

    repeat (3) @(negedge clock);
    checkOutput("reset O_I", int'(O_I), 0);
    checkOutput("reset O_PG", int'(O_PG), 0);
    checkOutput("reset O_Err", int'(O_Err), 0);
    checkOutput("reset O_Busy", int'(O_Busy), 0);
    I_Reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Exact strobe timing on the first valid group.
    pg0 = pgCount;
    applyStimulus(vecs[0].w, 3, j);
    expOI = vecs[0].expSym;
    checkOutput("first pg latency", lastPgCyc - j, 4);
    checkOutput("first pg pulses", pgCount - pg0, 1);
    checkOutput("first symbol", int'(O_I), int'(expOI));

    $display("[TB] table vectors");
    for (int i = 1; i < 5; i++) begin
      runGroup(vecs[i].name, vecs[i].w, 3, vecs[i].expValid, vecs[i].expSym);
    end

    // One-cycle glitch as the third bar, then a clean group.
    $display("[TB] glitch bar");
    pg0 = pgCount;
    e0  = errCount;
    holdLine(1'b1, 3);
    holdLine(1'b0, 3);
    holdLine(1'b1, 9);
    holdLine(1'b0, 3);
    holdLine(1'b1, 1);
    I_Scan = 1'b0;
    j = cyc + 1;
    repeat (6) @(negedge clock);
    checkOutput("glitch err pulses", errCount - e0, 1);
    checkOutput("glitch err latency", lastErrCyc - j, 2);
    checkOutput("glitch pg pulses", pgCount - pg0, 0);
    checkOutput("glitch busy", int'(O_Busy), 0);
    runGroup("after glitch", {8'd9, 8'd3, 8'd9, 8'd3, 8'd3}, 3, 1'b1, 5'b10100);

    // Two bars then silence: the space timeout must abort.
    $display("[TB] space timeout");
    pg0 = pgCount;
    e0  = errCount;
    holdLine(1'b1, 3);
    holdLine(1'b0, 3);
    holdLine(1'b1, 9);
    I_Scan = 1'b0;
    j = cyc + 1;
    repeat (40) @(negedge clock);
    checkOutput("timeout no early err", errCount - e0, 0);
    repeat (50) @(negedge clock);
    checkOutput("timeout err pulses", errCount - e0, 1);
    checkOutput("timeout err window",
                ((lastErrCyc - j) >= 62 && (lastErrCyc - j) <= 68) ? 1 : 0, 1);
    checkOutput("timeout pg pulses", pgCount - pg0, 0);
    checkOutput("timeout busy", int'(O_Busy), 0);

    // A bar long enough to saturate the width counter.
    $display("[TB] saturated bar");
    pg0 = pgCount;
    e0  = errCount;
    holdLine(1'b1, 300);
    holdLine(1'b0, 8);
    checkOutput("saturate err pulses", errCount - e0, 1);
    checkOutput("saturate pg pulses", pgCount - pg0, 0);
    checkOutput("saturate symbol", int'(O_I), int'(expOI));

    // Asynchronous reset in the middle of the third bar.
    $display("[TB] reset mid-symbol");
    holdLine(1'b1, 3);
    holdLine(1'b0, 3);
    holdLine(1'b1, 9);
    holdLine(1'b0, 3);
    I_Scan = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("pre-reset busy", int'(O_Busy), 1);
    #2;
    I_Reset_n = 1'b0;
    #1;
    expOI = '0;
    checkOutput("midreset O_I", int'(O_I), 0);
    checkOutput("midreset O_PG", int'(O_PG), 0);
    checkOutput("midreset O_Err", int'(O_Err), 0);
    checkOutput("midreset O_Busy", int'(O_Busy), 0);
    @(negedge clock);
    I_Scan = 1'b0;
    repeat (2) @(negedge clock);
    I_Reset_n = 1'b1;
    repeat (3) @(negedge clock);
    runGroup("after reset", {8'd9, 8'd9, 8'd3, 8'd3, 8'd3}, 3, 1'b1, 5'b11000);

    // Random groups judged by the reference model.
    $display("[TB] random groups");
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        nar = $urandom_range(2, 8);
        p1  = $urandom_range(0, 4);
        p2  = (p1 + $urandom_range(1, 4)) % 5;
        for (int k = 0; k < 5; k++) begin
          if (k == p1 || k == p2) rw[k] = 8'(2 * nar + 2 + $urandom_range(0, 4));
          else                    rw[k] = 8'(nar + $urandom_range(0, 1));
        end
      end else begin
        for (int k = 0; k < 5; k++) rw[k] = 8'($urandom_range(2, 30));
      end
      modelGroup(rw, mValid, mSym);
      runGroup($sformatf("rand%0d", i), rw, $urandom_range(2, 8), mValid, mSym);
    end

    checkOutput("output invariants", invViol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
